fp2int_iter: RTL and testbench

FP2INT_ITER -- requirements
Module: fp2int_iter

---
 rtl/fp_pkg.sv | 38 +++
 rtl/fp2int_iter.sv | 176 +++++++++++++++++
 tb/tb_fp2int_iter.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_pkg
//  Description : Shared FP32 field layout, integer limits and FSM state type
//                for the iterative FP32 -> int32 converter.
//  Revision    : 1.0 - initial release
// ============================================================================
package fp_pkg;

    // FP32 field layout: sign[31], exp[30:23], mantissa[22:0]
    localparam int FP_W   = 32;
    localparam int EXP_W  = 8;
    localparam int MANT_W = 23;

    localparam logic [EXP_W-1:0] BIAS       = 8'd127;
    // Unbiased exponent at which the mantissa point already sits at bit 0
    localparam logic [EXP_W-1:0] MANT_POINT = 8'd23;
    // Biased exponent of 2^31: anything at or above cannot fit in int32
    localparam logic [EXP_W-1:0] EXP_SAT    = 8'd158;

    localparam logic [31:0] INT32_MAX     = 32'h7FFF_FFFF;
    localparam logic [31:0] INT32_MIN     = 32'h8000_0000;
    // -2^31 is the only exp>=158 value that is exactly representable
    localparam logic [31:0] FP32_NEG_2P31 = 32'hCF00_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } fsm_state_t;

    // Two's-complement negate when neg is set
    function automatic logic [31:0] apply_sign(input logic neg, input logic [31:0] mag);
        return neg ? (~mag + 32'd1) : mag;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp2int_iter.sv
`default_nettype none
// ============================================================================
//  Module      : fp2int_iter
//  Description : FP32 -> signed int32 converter, truncating toward zero.
//                The mantissa is aligned by an iterative one-bit-per-cycle
//                shifter, so latency depends on the operand exponent
//                (1 .. 24 cycles).
//  Ports       : clk       - clock
//                reset     - asynchronous reset, active low
//                in_valid  - reg_A holds an operand
//                in_ready  - operand accepted this cycle (IDLE only)
//                reg_A     - FP32 operand
//                out_valid - out/ovf valid (DONE state)
//                out_ready - consumer takes the result
//                out       - signed integer result
//                ovf       - result saturated
//  Revision    : 1.0 - initial release
// ============================================================================
module fp2int_iter
    import fp_pkg::*;
#(
    parameter int OUT_W = 32    // only 32 is supported
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [FP_W-1:0]  reg_A,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out,
    output logic             ovf
);

    fsm_state_t       r_state;
    fsm_state_t       w_state_next;

    logic             r_started;   // keeps in_ready low until the first edge after reset
    logic [OUT_W-1:0] r_mag;
    logic [EXP_W-1:0] r_cnt;
    logic             r_left;
    logic             r_sign;
    logic [OUT_W-1:0] r_out;
    logic             r_ovf;

    logic             w_sign;
    logic [EXP_W-1:0] w_exp;
    logic [MANT_W-1:0] w_mant;
    logic             w_accept;
    logic             w_below;
    logic             w_sat;
    logic [EXP_W-1:0] w_e;
    logic             w_left;
    logic [EXP_W-1:0] w_shamt;
    logic             w_direct;
    logic [OUT_W-1:0] w_mag_load;
    logic [OUT_W-1:0] w_mag_shift;
    logic             w_last;

    // ------------------------------------------------------------------
    // Operand decode
    // ------------------------------------------------------------------
    assign w_sign     = reg_A[FP_W-1];
    assign w_exp      = reg_A[FP_W-2 -: EXP_W];
    assign w_mant     = reg_A[MANT_W-1:0];
    assign w_mag_load = {{(OUT_W-MANT_W-1){1'b0}}, 1'b1, w_mant};

    assign w_below    = (w_exp < BIAS);      // |x| < 1 truncates to 0
    assign w_sat      = (w_exp >= EXP_SAT);  // |x| >= 2^31, includes Inf/NaN
    // Unbiased exponent; only meaningful when neither w_below nor w_sat
    assign w_e        = w_exp - BIAS;
    assign w_left     = (w_e >= MANT_POINT);
    assign w_shamt    = w_left ? (w_e - MANT_POINT) : (MANT_POINT - w_e);
    // Results that need no shifting complete on the acceptance edge
    assign w_direct   = w_below | w_sat | (w_shamt == '0);

    assign w_accept   = in_valid & in_ready;

    // ------------------------------------------------------------------
    // Single-bit shifter step
    // ------------------------------------------------------------------
    assign w_mag_shift = r_left ? {r_mag[OUT_W-2:0], 1'b0} : {1'b0, r_mag[OUT_W-1:1]};
    assign w_last      = (r_cnt == 8'd1);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = w_direct ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_started <= 1'b0;
            r_mag     <= '0;
            r_cnt     <= '0;
            r_left    <= 1'b0;
            r_sign    <= 1'b0;
            r_out     <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_started <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_sign <= w_sign;
                        r_left <= w_left;
                        r_cnt  <= w_shamt;
                        r_mag  <= w_mag_load;
                        if (w_below) begin
                            r_out <= '0;
                            r_ovf <= 1'b0;
                        end else if (w_sat) begin
                            if (reg_A == FP32_NEG_2P31) begin
                                r_out <= INT32_MIN;
                                r_ovf <= 1'b0;
                            end else begin
                                r_out <= w_sign ? INT32_MIN : INT32_MAX;
                                r_ovf <= 1'b1;
                            end
                        end else if (w_shamt == '0) begin
                            r_out <= apply_sign(w_sign, w_mag_load);
                            r_ovf <= 1'b0;
                        end
                    end
                end
                SHIFT: begin
                    r_mag <= w_mag_shift;
                    r_cnt <= r_cnt - 8'd1;
                    // Final step: register the freshly shifted magnitude directly
                    if (w_last) begin
                        r_out <= apply_sign(r_sign, w_mag_shift);
                        r_ovf <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = r_started & (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign out       = r_out;
    assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_fp2int_iter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp2int_iter
//  Description : Scoreboard testbench for fp2int_iter. A driver issues
//                directed and random operands and pushes expected results;
//                a monitor acting as consumer pops and compares results,
//                latency, hold-stability under backpressure and handshakes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp2int_iter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] reg_A;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic        ovf;

    fp2int_iter #(.OUT_W(32)) dut (
        .clk       (clk),
        .reset     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .reg_A     (reg_A),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] res;
        logic        o;
        int          lat;
        int          acc;
        int          bp;
    } exp_t;

    exp_t sb_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Reference: value = (-1)^s * 1.m * 2^(exp-127), truncated toward zero,
    // saturated when outside the int32 range. Latency is 1 for anything
    // outside biased exponents 127..157, else |E-23|+1.
    function automatic void ref_model(input logic [31:0] a, output logic [31:0] r,
                                      output logic o, output int lat);
        int     ex;
        int     e;
        longint mag;
        longint val;
        bit     sat;
        ex  = int'(a[30:23]);
        sat = 1'b0;
        val = 0;
        if (ex >= 127 && ex <= 157) lat = ((ex > 150) ? (ex - 150) : (150 - ex)) + 1;
        else                        lat = 1;
        if (ex < 127) begin
            r = 32'h0;
            o = 1'b0;
            return;
        end
        e = ex - 127;
        if (ex == 255 || e >= 32) begin
            sat = 1'b1;
        end else begin
            mag = 64'd8388608 + longint'(a[22:0]);
            if (e >= 23) mag = mag << (e - 23);
            else         mag = mag >> (23 - e);
            val = a[31] ? -mag : mag;
            if (val > 64'sd2147483647 || val < -64'sd2147483648) sat = 1'b1;
        end
        if (sat) begin
            r = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
            o = 1'b1;
        end else begin
            r = val[31:0];
            o = 1'b0;
        end
    endfunction

    // ------------------------------------------------------------------
    // Driver
    // ------------------------------------------------------------------
    task automatic issue(input logic [31:0] a, input int bp, input bit use_tab,
                         input logic [31:0] t_res, input logic t_o, input int t_lat);
        exp_t e;
        int   guard;
        guard = 0;
        @(negedge clk);
        reg_A    = a;
        in_valid = 1'b1;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        e.a = a;
        if (use_tab) begin
            e.res = t_res;
            e.o   = t_o;
            e.lat = t_lat;
        end else begin
            ref_model(a, e.res, e.o, e.lat);
        end
        e.acc = cyc + 1;
        e.bp  = bp;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        reg_A    = $urandom;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((sb_q.size() != 0 || out_valid) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) chk("drain_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Monitor / consumer
    // ------------------------------------------------------------------
    bit          mon_seen = 1'b0;
    bit          mon_post = 1'b0;
    int          mon_stall = 0;
    logic [31:0] mon_out;
    logic        mon_ovf;
    exp_t        mon_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            mon_seen  = 1'b0;
            mon_post  = 1'b0;
            mon_stall = 0;
        end else begin
            if (mon_post) begin
                chk("idle_after_hs_in_ready", {31'd0, in_ready}, 32'd1);
                chk("idle_after_hs_out_valid", {31'd0, out_valid}, 32'd0);
                mon_post = 1'b0;
            end
            if (out_valid) begin
                if (!mon_seen) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_out_valid", 32'd1, 32'd0);
                        mon_stall = 0;
                    end else begin
                        mon_e = sb_q.pop_front();
                        chk("result", out, mon_e.res);
                        chk("ovf", {31'd0, ovf}, {31'd0, mon_e.o});
                        chk("latency", 32'(cyc - mon_e.acc + 1), 32'(mon_e.lat));
                        mon_stall = mon_e.bp;
                    end
                    mon_out  = out;
                    mon_ovf  = ovf;
                    mon_seen = 1'b1;
                end else begin
                    chk("hold_out", out, mon_out);
                    chk("hold_ovf", {31'd0, ovf}, {31'd0, mon_ovf});
                end
                chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
                if (mon_stall > 0) begin
                    out_ready = 1'b0;
                    mon_stall--;
                end else begin
                    out_ready = 1'b1;
                    mon_seen  = 1'b0;
                    mon_post  = 1'b1;
                end
            end else begin
                out_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    logic [31:0] ra;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        reg_A     = 32'h0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out", out, 32'h0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_reset", {31'd0, in_ready}, 32'd1);

        // Directed operands with hand-derived results
        issue(32'h3F80_0000, 0, 1'b1, 32'h0000_0001, 1'b0, 24);
        issue(32'hC2F6_E979, 1, 1'b1, 32'hFFFF_FF85, 1'b0, 18);
        issue(32'h4EFF_FFFF, 0, 1'b1, 32'h7FFF_FF80, 1'b0, 8);
        issue(32'h4F00_0000, 0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1);
        issue(32'hCF00_0000, 2, 1'b1, 32'h8000_0000, 1'b0, 1);
        issue(32'h7FC0_0000, 0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1);
        issue(32'h3F00_0000, 0, 1'b1, 32'h0000_0000, 1'b0, 1);
        issue(32'hCB00_0001, 0, 1'b1, 32'hFF7F_FFFF, 1'b0, 1);   // -8388609, no shift
        issue(32'hFF80_0000, 0, 1'b1, 32'h8000_0000, 1'b1, 1);   // -Inf
        drain();

        // Backpressure: result held for 5 stalled cycles
        issue(32'h3F80_0000, 5, 1'b1, 32'h0000_0001, 1'b0, 24);
        drain();

        // Reset in the middle of a shift sequence
        issue(32'h3F80_0000, 0, 1'b1, 32'h0000_0001, 1'b0, 24);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_out", out, 32'h0);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready_release", {31'd0, in_ready}, 32'd1);
        chk("midrst_no_stale_valid", {31'd0, out_valid}, 32'd0);
        issue(32'h4040_0000, 0, 1'b1, 32'h0000_0003, 1'b0, 23);
        drain();

        // Randomised operands against the reference model
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                ra = $urandom;
            end else begin
                ra = {1'($urandom_range(0, 1)), 8'($urandom_range(120, 160)), 23'($urandom)};
            end
            issue(ra, int'($urandom_range(0, 3)), 1'b0, 32'h0, 1'b0, 0);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
